// File: rtl/gpio_uart_expander_if.sv
// ---------------------------------------------------------------------------
// gpio_uart_expander_if
//   Pad bundle between the GPIO wrapper and the UART GPIO expander core.
//
//   io_in  [35:0] : pad input values (wrapper -> core)
//   io_out [35:0] : pad output values (core -> wrapper)
//   io_oeb [35:0] : pad output-enable, active-low, 1 = input/hi-Z (core -> wrapper)
//
//   master : wrapper / testbench side
//   slave  : expander core side
// ---------------------------------------------------------------------------
interface gpio_uart_expander_if;
    logic [35:0] io_in;
    logic [35:0] io_out;
    logic [35:0] io_oeb;

    modport master (output io_in, input io_out, input io_oeb);
    modport slave  (input io_in, output io_out, output io_oeb);
endinterface

// File: rtl/gpio_uart_expander.sv
// ---------------------------------------------------------------------------
// gpio_uart_expander
//   UART-controlled GPIO expander. A host sends one-byte commands on pad 0
//   (RX); the core drives, releases or reads back pads 35..2. Read responses
//   go out as UART frames on pad 1 (TX).
//
//   Command byte: [7:6] op, [5:0] pin index (valid 2..35)
//     00 drive low, 01 drive high, 10 release (output value kept),
//     11 read -> replies '0'/'1', or '?' for an invalid index.
//
//   Ports:
//     clk_i : core clock
//     rst_n : synchronous active-low reset
//     pads  : gpio_uart_expander_if.slave (io_in, io_out, io_oeb)
//
//   Parameter CLK_DIV : clock cycles per UART bit (>= 4).
//   Optional macro GPIO_EXP_ACK_EN : write commands reply '.' when accepted
//   and '?' when rejected; without it, writes produce no TX traffic.
// ---------------------------------------------------------------------------
module gpio_uart_expander #(
    parameter int CLK_DIV = 104
) (
    input  logic                clk_i,
    input  logic                rst_n,
    gpio_uart_expander_if.slave pads
);

    localparam int CW = $clog2(CLK_DIV) + 1;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Response for a decoded command: {load, byte}.
    function automatic logic [8:0] resp_fn(input logic [1:0] op, input logic idx_ok,
                                           input logic pin);
        logic [8:0] r;
        r = 9'h000;
        if (op == 2'b11) begin
            r = idx_ok ? {1'b1, 7'b0011000, pin} : {1'b1, 8'h3F};
        end else begin
`ifdef GPIO_EXP_ACK_EN
            r = idx_ok ? {1'b1, 8'h2E} : {1'b1, 8'h3F};
`else
            r = 9'h000;
`endif
        end
        return r;
    endfunction

    // ---- stage p0/p1: two-flop input synchronizer ----
    logic [35:0] sync_p0, sync_p1;
    logic        rx_line, rx_prev;

    always_ff @(posedge clk_i) begin
        sync_p0 <= pads.io_in;
        sync_p1 <= sync_p0;
    end

    assign rx_line = sync_p1[0];

    // rx_prev resets low so a line that is low after reset cannot fake a start edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n) rx_prev <= 1'b0;
        else        rx_prev <= rx_line;
    end

    // ---- RX frame decoder ----
    rx_state_t       rx_state, rx_state_nxt;
    logic [CW-1:0]   rx_cnt, rx_cnt_nxt;
    logic [2:0]      rx_bit, rx_bit_nxt;
    logic [7:0]      rx_shift, rx_shift_nxt;
    logic            rx_vld;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
        end
    end

    always_ff @(posedge clk_i) rx_shift <= rx_shift_nxt;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_vld       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_line) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = CW'(CLK_DIV / 2);
                end
            end
            RX_START: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nxt = rx_cnt - CW'(1);
                end else if (rx_line) begin
                    rx_state_nxt = RX_IDLE;           // start bit did not hold: glitch
                end else begin
                    rx_state_nxt = RX_DATA;
                    rx_cnt_nxt   = CW'(CLK_DIV - 1);
                    rx_bit_nxt   = '0;
                end
            end
            RX_DATA: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nxt = rx_cnt - CW'(1);
                end else begin
                    rx_shift_nxt = {rx_line, rx_shift[7:1]};
                    rx_cnt_nxt   = CW'(CLK_DIV - 1);
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nxt = rx_cnt - CW'(1);
                end else if (rx_line) begin
                    rx_vld       = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end else begin
                    rx_state_nxt = RX_BREAK;          // framing error: drop byte
                end
            end
            RX_BREAK: begin
                if (rx_line) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---- command execute: pin registers and response buffer load ----
    logic [1:0]  op;
    logic [5:0]  idx;
    logic        idx_ok;
    logic        pin_val;
    logic [8:0]  resp;
    logic        resp_load;
    logic [35:2] out_r, oeb_r;

    assign op        = rx_shift[7:6];
    assign idx       = rx_shift[5:0];
    assign idx_ok    = (idx >= 6'd2) && (idx <= 6'd35);
    assign pin_val   = idx_ok ? sync_p1[idx] : 1'b0;
    assign resp      = resp_fn(op, idx_ok, pin_val);
    assign resp_load = rx_vld && resp[8];

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            out_r <= '0;
            oeb_r <= '1;
        end else if (rx_vld && idx_ok) begin
            case (op)
                2'b00: begin out_r[idx] <= 1'b0; oeb_r[idx] <= 1'b0; end
                2'b01: begin out_r[idx] <= 1'b1; oeb_r[idx] <= 1'b0; end
                2'b10: oeb_r[idx] <= 1'b1;
                default: ;
            endcase
        end
    end

    // ---- TX serializer ----
    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          tx_take;
    logic          buf_full;
    logic [7:0]    buf_data;
    logic          tx_line;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            buf_full <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            // A load wins over the take, so a response arriving as the
            // previous one is consumed is kept rather than lost.
            buf_full <= resp_load ? 1'b1 : (tx_take ? 1'b0 : buf_full);
        end
    end

    always_ff @(posedge clk_i) begin
        tx_shift <= tx_shift_nxt;
        if (resp_load) buf_data <= resp[7:0];
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_take      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (buf_full) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = CW'(CLK_DIV - 1);
                    tx_shift_nxt = buf_data;
                    tx_take      = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt != '0) begin
                    tx_cnt_nxt = tx_cnt - CW'(1);
                end else begin
                    tx_state_nxt = TX_DATA;
                    tx_cnt_nxt   = CW'(CLK_DIV - 1);
                    tx_bit_nxt   = '0;
                end
            end
            TX_DATA: begin
                if (tx_cnt != '0) begin
                    tx_cnt_nxt = tx_cnt - CW'(1);
                end else begin
                    tx_cnt_nxt   = CW'(CLK_DIV - 1);
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
                    else                tx_bit_nxt   = tx_bit + 3'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt != '0) tx_cnt_nxt   = tx_cnt - CW'(1);
                else              tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        if (tx_state == TX_START)     tx_line = 1'b0;
        else if (tx_state == TX_DATA) tx_line = tx_shift[0];
    end

    // ---- pad outputs: pad 0 is a fixed input, pad 1 a fixed output ----
    assign pads.io_out = {out_r, tx_line, 1'b0};
    assign pads.io_oeb = {oeb_r, 2'b01};

endmodule

// File: tb/tb_gpio_uart_expander.sv
// ---------------------------------------------------------------------------
// tb_gpio_uart_expander
//   Directed testbench for gpio_uart_expander with CLK_DIV = 8. Drives UART
//   command frames on pad 0, checks pad registers against a small expected
//   pin model and decodes TX frames on pad 1 sample by sample.
//   Honors GPIO_EXP_ACK_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_gpio_uart_expander;

    localparam int CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    logic [35:0] exp_out;
    logic [35:0] exp_oeb;

    gpio_uart_expander_if pads();

    gpio_uart_expander #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .pads  (pads)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        pads.io_in[0] = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            pads.io_in[0] = b[i];
            tick(CLK_DIV);
        end
        pads.io_in[0] = stop_bit;
        tick(CLK_DIV);
        pads.io_in[0] = 1'b1;
    endtask

    // Drive only the first n clocks of a frame, leaving it unfinished.
    task automatic send_partial(input logic [7:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            int slot;
            slot = k / CLK_DIV;
            if (slot == 0)      pads.io_in[0] = 1'b0;
            else if (slot <= 8) pads.io_in[0] = b[slot-1];
            else                pads.io_in[0] = 1'b1;
            tick(1);
        end
    endtask

    task automatic check_pins(input string tag);
        check({tag, " out"}, pads.io_out, exp_out);
        check({tag, " oeb"}, pads.io_oeb, exp_oeb);
    endtask

    task automatic wait_tx_start(input string tag, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (pads.io_out[1] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({tag, " tx start"}, 0, 1);
    endtask

    // Records 10 bit-slots of CLK_DIV samples each from the first low sample.
    task automatic capture_frame(input string tag, input logic [7:0] b);
        bit          ok;
        logic [79:0] obs;
        logic [79:0] expv;
        logic [7:0]  got;
        wait_tx_start(tag, ok);
        if (ok) begin
            obs = '0;
            for (int k = 1; k < 80; k++) begin
                @(negedge clk);
                obs[k] = pads.io_out[1];
            end
            for (int s = 0; s < 10; s++) begin
                for (int j = 0; j < CLK_DIV; j++) begin
                    if (s == 0)      expv[s*CLK_DIV+j] = 1'b0;
                    else if (s == 9) expv[s*CLK_DIV+j] = 1'b1;
                    else             expv[s*CLK_DIV+j] = b[s-1];
                end
            end
            for (int i = 0; i < 8; i++) got[i] = obs[(i+1)*CLK_DIV + CLK_DIV/2];
            check({tag, " byte"}, got, b);
            check({tag, " frame"}, obs, expv);
        end
    endtask

    task automatic quiet(input string tag, input int n);
        int lows;
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (pads.io_out[1] !== 1'b1) lows++;
        end
        check({tag, " tx idle"}, lows, 0);
    endtask

    task automatic write_resp(input string tag, input bit accepted);
`ifdef GPIO_EXP_ACK_EN
        capture_frame(tag, accepted ? 8'h2E : 8'h3F);
`else
        if (accepted || !accepted) quiet(tag, 120);
`endif
    endtask

    task automatic do_reset_model();
        exp_out = 36'h0_0000_0002;
        exp_oeb = 36'hF_FFFF_FFFD;
    endtask

    initial begin
        bit ok;
        rst_n       = 1'b0;
        pads.io_in  = 36'h0_0000_0001;
        do_reset_model();

        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset tx high", pads.io_out[1], 1'b1);
        check_pins("in reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
        check_pins("after reset");
        check("idle tx high", pads.io_out[1], 1'b1);

        // Writes on pin 5
        send_byte(8'h45, 1'b1);
        exp_out[5] = 1'b1; exp_oeb[5] = 1'b0;
        check_pins("w45");
        write_resp("w45", 1'b1);
        send_byte(8'h05, 1'b1);
        exp_out[5] = 1'b0;
        check_pins("w05");
        write_resp("w05", 1'b1);
        send_byte(8'h45, 1'b1);
        exp_out[5] = 1'b1;
        check_pins("w45b");
        write_resp("w45b", 1'b1);
        send_byte(8'h85, 1'b1);
        exp_oeb[5] = 1'b1;
        check_pins("w85");
        write_resp("w85", 1'b1);

        // Index boundaries 35 and 2
        send_byte(8'h63, 1'b1);
        exp_out[35] = 1'b1; exp_oeb[35] = 1'b0;
        check_pins("w63");
        write_resp("w63", 1'b1);
        send_byte(8'h02, 1'b1);
        exp_out[2] = 1'b0; exp_oeb[2] = 1'b0;
        check_pins("w02");
        write_resp("w02", 1'b1);
        send_byte(8'hA3, 1'b1);
        exp_oeb[35] = 1'b1;
        check_pins("wA3");
        write_resp("wA3", 1'b1);

        // Reads
        pads.io_in[7] = 1'b1;
        send_byte(8'hC7, 1'b1);
        capture_frame("rd7 hi", 8'h31);
        pads.io_in[7] = 1'b0;
        send_byte(8'hC7, 1'b1);
        capture_frame("rd7 lo", 8'h30);
        pads.io_in[2] = 1'b1;
        send_byte(8'hC2, 1'b1);
        capture_frame("rd2", 8'h31);
        pads.io_in[35] = 1'b1;
        send_byte(8'hE3, 1'b1);
        capture_frame("rd35", 8'h31);

        // Invalid indices
        send_byte(8'h41, 1'b1);
        check_pins("w41");
        write_resp("w41", 1'b0);
        send_byte(8'h64, 1'b1);
        check_pins("w64");
        write_resp("w64", 1'b0);
        send_byte(8'hC0, 1'b1);
        capture_frame("rd0", 8'h3F);
        send_byte(8'hE4, 1'b1);
        capture_frame("rd36", 8'h3F);

        // Start-bit glitch and framing error
        pads.io_in[0] = 1'b0;
        tick(3);
        pads.io_in[0] = 1'b1;
        tick(20);
        check_pins("glitch");
        quiet("glitch", 100);
        send_byte(8'h45, 1'b0);
        check_pins("frame err");
        quiet("frame err", 100);
        send_byte(8'h45, 1'b1);
        exp_oeb[5] = 1'b0;
        check_pins("w45 after err");
        write_resp("w45 after err", 1'b1);

        // Reset in the middle of an RX frame
        send_partial(8'h45, 40);
        rst_n = 1'b0;
        pads.io_in[0] = 1'b1;
        tick(1);
        @(negedge clk);
        do_reset_model();
        check_pins("rst mid rx");
        check("rst mid rx tx", pads.io_out[1], 1'b1);
        rst_n = 1'b1;
        quiet("after rx rst", 100);
        check_pins("after rx rst");

        // Reset in the middle of a TX frame
        send_byte(8'h63, 1'b1);
        exp_out[35] = 1'b1; exp_oeb[35] = 1'b0;
        check_pins("w63 pre tx rst");
        write_resp("w63 pre tx rst", 1'b1);
        pads.io_in[7] = 1'b1;
        send_byte(8'hC7, 1'b1);
        wait_tx_start("rst mid tx", ok);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        do_reset_model();
        check_pins("rst mid tx");
        check("rst mid tx line", pads.io_out[1], 1'b1);
        rst_n = 1'b1;
        quiet("after tx rst", 120);

        // Full traffic after reset
        send_byte(8'h45, 1'b1);
        exp_out[5] = 1'b1; exp_oeb[5] = 1'b0;
        check_pins("w45 post rst");
        write_resp("w45 post rst", 1'b1);
        send_byte(8'hC7, 1'b1);
        capture_frame("rd7 post rst", 8'h31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
